// File: rtl/quad_dir_decoder.sv
// Quadrature encoder front end: synchronise, debounce and decode A/B into step + direction.
// Optional feature: define QDEC_X4_EN for x4 decoding (step on every legal transition);
// otherwise x1 decoding (step only on 10->00 forward and 01->00 reverse).
module quad_dir_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter bit          DIR_RESET   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       clr,
  output logic       step,
  output logic       up_down,
  output logic       err,
  output logic [1:0] state_ab
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned INIT_W = 3;
  localparam int unsigned LAST   = SYNC_STAGES - 1;

  typedef enum logic {
    S_INIT,
    S_TRACK
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]       cnt_b_q, cnt_b_d;
  logic                   filt_a_q, filt_a_d;
  logic                   filt_b_q, filt_b_d;
  logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
  logic [1:0]             prev_q, prev_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic                   err_q, err_d;

  logic       init_done_c;
  logic [1:0] cur_c;
  logic       fwd_c;
  logic       rev_c;
  logic       ill_c;

  // INIT ends on the edge where the last sync stage takes its first post-reset sample
  assign init_done_c = (init_cnt_q == INIT_W'(SYNC_STAGES - 1));
  assign cur_c       = {filt_a_q, filt_b_q};
  // Forward order 00->01->11->10->00: next forward = {p[0], ~p[1]}, next reverse = {~p[0], p[1]}
  assign fwd_c       = (cur_c == {prev_q[0], ~prev_q[1]});
  assign rev_c       = (cur_c == {~prev_q[0], prev_q[1]});
  assign ill_c       = ((cur_c ^ prev_q) == 2'b11);

  // Synchroniser shift and per-channel debounce filter; INIT seeds the filtered levels
  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b};
    cnt_a_d  = '0;
    cnt_b_d  = '0;
    filt_a_d = filt_a_q;
    filt_b_d = filt_b_q;
    if (state_q == S_INIT) begin
      if (init_done_c) begin
        filt_a_d = sync_a_d[LAST];
        filt_b_d = sync_b_d[LAST];
      end
    end else begin
      if (sync_a_q[LAST] != filt_a_q) begin
        if (cnt_a_q == CNT_W'(FILT_LEN - 1)) filt_a_d = sync_a_q[LAST];
        else                                  cnt_a_d  = cnt_a_q + CNT_W'(1);
      end
      if (sync_b_q[LAST] != filt_b_q) begin
        if (cnt_b_q == CNT_W'(FILT_LEN - 1)) filt_b_d = sync_b_q[LAST];
        else                                  cnt_b_d  = cnt_b_q + CNT_W'(1);
      end
    end
  end

  // FSM next state and decode of prev -> cur transitions
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = clr ? 1'b0 : err_q;
    case (state_q)
      S_INIT: begin
        if (init_done_c) begin
          state_d = S_TRACK;
          prev_d  = {filt_a_d, filt_b_d};
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      S_TRACK: begin
        prev_d = cur_c;
        if (ill_c) begin
          err_d = 1'b1;
        end else if (fwd_c) begin
          dir_d = 1'b0;
`ifdef QDEC_X4_EN
          step_d = 1'b1;
`else
          step_d = (prev_q == 2'b10);
`endif
        end else if (rev_c) begin
          dir_d = 1'b1;
`ifdef QDEC_X4_EN
          step_d = 1'b1;
`else
          step_d = (prev_q == 2'b01);
`endif
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      filt_a_q   <= 1'b0;
      filt_b_q   <= 1'b0;
      init_cnt_q <= '0;
      prev_q     <= 2'b00;
      step_q     <= 1'b0;
      dir_q      <= DIR_RESET;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      filt_a_q   <= filt_a_d;
      filt_b_q   <= filt_b_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign step     = step_q;
  assign up_down  = dir_q;
  assign err      = err_q;
  assign state_ab = {filt_a_q, filt_b_q};

endmodule

// File: tb/tb_quad_dir_decoder.sv
// Testbench for quad_dir_decoder: scoreboard of expected step pulses (cycle + direction).
module tb_quad_dir_decoder;

  localparam int LAT  = 7;
  localparam int HOLD = 10;

  typedef struct packed {
    logic [31:0] cyc;
    logic        dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enc_a;
  logic       enc_b;
  logic       clr;
  logic       step;
  logic       up_down;
  logic       err;
  logic [1:0] state_ab;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic step_last = 1'b0;

  logic [1:0] m_ab;
  logic       m_dir;
  logic       m_err;

  quad_dir_decoder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .clr      (clr),
    .step     (step),
    .up_down  (up_down),
    .err      (err),
    .state_ab (state_ab)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // 0 = no change, 1 = forward, 2 = reverse, 3 = illegal
  function automatic logic [1:0] classify(input logic [1:0] p, input logic [1:0] c);
    logic [1:0] nf, nr;
    case (p)
      2'b00:   begin nf = 2'b01; nr = 2'b10; end
      2'b01:   begin nf = 2'b11; nr = 2'b00; end
      2'b11:   begin nf = 2'b10; nr = 2'b01; end
      default: begin nf = 2'b00; nr = 2'b11; end
    endcase
    if (c == p)  return 2'd0;
    if (c == nf) return 2'd1;
    if (c == nr) return 2'd2;
    return 2'd3;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a new A/B level and push the step it should produce
  task automatic drive(input logic [1:0] ab);
    logic [1:0] k;
    logic       stp;
    exp_t       e;
    k     = classify(m_ab, ab);
    enc_a = ab[1];
    enc_b = ab[0];
    if (k == 2'd3) begin
      m_err = 1'b1;
    end else if (k != 2'd0) begin
      m_dir = (k == 2'd2);
`ifdef QDEC_X4_EN
      stp = 1'b1;
`else
      stp = (ab == 2'b00);
`endif
      if (stp) begin
        e.cyc = 32'(cyc + LAT);
        e.dir = m_dir;
        sb_q.push_back(e);
      end
    end
    m_ab = ab;
  endtask

  task automatic apply(input logic [1:0] ab);
    drive(ab);
    wait_clk(HOLD);
    chk("state_ab", 32'(state_ab), 32'(m_ab));
    chk("up_down", 32'(up_down), 32'(m_dir));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic drained(input string tag);
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Step monitor: every pulse must be expected, on time, with the right direction, one cycle wide
  always @(negedge clk) begin
    if (step === 1'b1) begin
      chk("step_2cyc", 32'(step_last), 32'd0);
      chk("step_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("step_cyc", 32'(cyc), mon_e.cyc);
        chk("step_dir", 32'(up_down), 32'(mon_e.dir));
      end
    end
    step_last = step;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    enc_a   = 1'b1;
    enc_b   = 1'b1;
    clr     = 1'b0;
    m_ab    = 2'b11;
    m_dir   = 1'b0;
    m_err   = 1'b0;

    // Reset values while encoder rests at 11
    #3;
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dir", 32'(up_down), 32'd0);
    chk("rst_ab", 32'(state_ab), 32'd0);
    wait_clk(2);
    chk("rst_ab_hold", 32'(state_ab), 32'd0);

    // Release: INIT loads 11 after two clocks, no err, no step
    reset_n = 1'b1;
    wait_clk(2);
    chk("init_ab", 32'(state_ab), 32'd3);
    chk("init_step", 32'(step), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    wait_clk(8);
    drained("init_drain");

    // Forward: back to 00 then a full forward cycle
    apply(2'b10);
    apply(2'b00);
    apply(2'b01);
    apply(2'b11);
    apply(2'b10);
    apply(2'b00);
    drained("fwd_drain");

    // Reverse full cycle
    apply(2'b10);
    apply(2'b11);
    apply(2'b01);
    apply(2'b00);
    drained("rev_drain");

    // 3-cycle glitch on A is discarded
    enc_a = 1'b1;
    wait_clk(3);
    enc_a = 1'b0;
    wait_clk(HOLD);
    chk("glitch3_ab", 32'(state_ab), 32'd0);
    chk("glitch3_err", 32'(err), 32'd0);

    // 4-cycle pulse on A is accepted, then its return to 0 as well
    drive(2'b10);
    wait_clk(4);
    drive(2'b00);
    wait_clk(2);
    chk("pulse4_ab", 32'(state_ab), 32'd2);
    wait_clk(HOLD);
    chk("pulse4_ret_ab", 32'(state_ab), 32'd0);
    drained("pulse_drain");

    // Illegal 00->11: err set, direction held, no step
    apply(2'b11);
    clr = 1'b1;
    wait_clk(1);
    clr = 1'b0;
    m_err = 1'b0;
    chk("clr_err", 32'(err), 32'd0);

    // Illegal 11->00 with clr in the same cycle: set wins
    drive(2'b00);
    wait_clk(LAT - 1);
    chk("pre_ill_err", 32'(err), 32'd0);
    clr = 1'b1;
    wait_clk(1);
    clr = 1'b0;
    chk("set_wins_err", 32'(err), 32'd1);
    wait_clk(HOLD);
    chk("set_wins_hold", 32'(err), 32'(m_err));
    drained("ill_drain");

    // Reset mid-sequence with err=1 and up_down=1
    apply(2'b10);
    drive(2'b11);
    wait_clk(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_step", 32'(step), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_dir", 32'(up_down), 32'd0);
    chk("mid_rst_ab", 32'(state_ab), 32'd0);
    sb_q.delete();
    m_ab  = 2'b11;
    m_dir = 1'b0;
    m_err = 1'b0;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(2);
    chk("rel_ab", 32'(state_ab), 32'd3);
    chk("rel_err", 32'(err), 32'd0);
    wait_clk(8);
    drained("rel_drain");

    // Tracking resumes
    apply(2'b10);
    apply(2'b00);
    apply(2'b01);
    drained("final_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
